// File: rtl/muldiv_pkg.sv
// muldiv_pkg -- shared definitions for the execute-stage multiply/divide unit.
// Contents: datapath width, iteration count, RV32M funct3 encodings,
// FSM state encoding, fixed special-case results and a small negate helper.
package muldiv_pkg;

    localparam int XLEN  = 32;
    localparam int ITER  = XLEN;
    localparam int CNT_W = $clog2(ITER);

    // funct3 encodings of the M extension
    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [XLEN-1:0] DIV0_QUOT = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] INT_MIN   = {1'b1, {(XLEN-1){1'b0}}};

    // Two's-complement negate when en is set.
    function automatic logic [XLEN-1:0] neg_if(input logic en, input logic [XLEN-1:0] v);
        return en ? -v : v;
    endfunction

endpackage

// File: rtl/ex_muldiv_unit_if.sv
// ex_muldiv_unit_if -- request/response bundle between the ID/EX stage and the
// multiply/divide unit.
// Request  (master -> slave): flush, req_valid, op, a, b, wa_in
// Response (slave -> master): stall, busy, result_valid, result, wa_out
interface ex_muldiv_unit_if;
    import muldiv_pkg::*;

    logic            flush;
    logic            req_valid;
    logic [2:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [4:0]      wa_in;

    logic            stall;
    logic            busy;
    logic            result_valid;
    logic [XLEN-1:0] result;
    logic [4:0]      wa_out;

    modport master (
        output flush, req_valid, op, a, b, wa_in,
        input  stall, busy, result_valid, result, wa_out
    );

    modport slave (
        input  flush, req_valid, op, a, b, wa_in,
        output stall, busy, result_valid, result, wa_out
    );

endinterface

// File: rtl/muldiv_iter_core.sv
// muldiv_iter_core -- one-bit-per-cycle shift/add (multiply) and restoring
// shift/subtract (divide) datapath on unsigned magnitudes.
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   load         - start a new operation: hi=0, lo=a_mag, divisor/multiplicand=b_mag
//   step         - perform one iteration
//   is_mul       - select multiply step (absent when MULDIV_FAST_MUL_EN is defined)
//   a_mag, b_mag - operand magnitudes
//   hi, lo       - multiply: product[2*XLEN-1:XLEN] / product[XLEN-1:0]
//                  divide:   remainder / quotient
// Build option: MULDIV_FAST_MUL_EN removes the multiply step entirely.
module muldiv_iter_core
    import muldiv_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            step,
`ifndef MULDIV_FAST_MUL_EN
    input  logic            is_mul,
`endif
    input  logic [XLEN-1:0] a_mag,
    input  logic [XLEN-1:0] b_mag,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    logic [XLEN-1:0] hi_q, lo_q, b_q;
    logic [XLEN-1:0] hi_d, lo_d;
    logic [XLEN:0]   div_shift, div_diff;

    // Divide: dividend bits leave the top of lo while quotient bits enter at
    // the bottom. The remainder is always below the divisor, so a failed
    // subtract leaves a value that still fits in XLEN bits.
    assign div_shift = {hi_q, lo_q[XLEN-1]};
    assign div_diff  = div_shift - {1'b0, b_q};

`ifndef MULDIV_FAST_MUL_EN
    // Multiply: add the multiplicand to the upper half when the current
    // multiplier bit is set, then shift the whole product (with carry) right.
    logic [XLEN:0] mul_sum;
    assign mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
`endif

    // NOTE: every output of a combinational block gets a default first, so no
    // path through it leaves a signal unassigned and a latch is never inferred.
    always_comb begin
        hi_d = div_diff[XLEN] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0];
        lo_d = {lo_q[XLEN-2:0], ~div_diff[XLEN]};
`ifndef MULDIV_FAST_MUL_EN
        if (is_mul) begin
            hi_d = mul_sum[XLEN:1];
            lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
        end
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order. Reset is
    // synchronous: it only takes effect on a rising clock edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q <= '0;
            lo_q <= '0;
            b_q  <= '0;
        end else if (load) begin
            hi_q <= '0;
            lo_q <= a_mag;
            b_q  <= b_mag;
        end else if (step) begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    assign hi = hi_q;
    assign lo = lo_q;

endmodule

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit -- iterative RV32M multiply/divide unit in the execute stage.
// Accepts one M-extension instruction from ID/EX, stalls the front end while it
// iterates, and returns a one-cycle result strobe with result and destination.
// Ports:
//   clk - clock, all state updates on the rising edge
//   rst - synchronous active-high reset
//   bus - ex_muldiv_unit_if.slave:
//         in : flush, req_valid, op (funct3), a (rs1), b (rs2), wa_in
//         out: stall, busy, result_valid, result, wa_out
// Build option: MULDIV_FAST_MUL_EN -- multiplies complete combinationally
// (IDLE->DONE); divides remain iterative.
module ex_muldiv_unit
    import muldiv_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    ex_muldiv_unit_if.slave bus
);

    state_t          state_q, state_d;
    logic [2:0]      op_q;
    logic [4:0]      wa_q;
    logic            sa_q, sb_q;
    logic [CNT_W-1:0] cnt_q;
    logic [XLEN-1:0] result_q;
    logic [4:0]      wa_out_q;

    logic            accept;
    logic            signed_a, signed_b, sa_in, sb_in;
    logic            b_zero, div_ovf, direct_done;
    logic [XLEN-1:0] a_mag, b_mag, direct_res, fix_res;
    logic [XLEN-1:0] core_hi, core_lo;
    logic            core_load, core_step;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    assign accept   = (state_q == IDLE) && bus.req_valid && !bus.flush;
    assign signed_a = bus.op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    assign signed_b = bus.op inside {OP_MULH, OP_DIV, OP_REM};
    assign sa_in    = signed_a & bus.a[XLEN-1];
    assign sb_in    = signed_b & bus.b[XLEN-1];
    assign a_mag    = neg_if(sa_in, bus.a);
    assign b_mag    = neg_if(sb_in, bus.b);
    assign b_zero   = (bus.b == '0);
    assign div_ovf  = (bus.a == INT_MIN) && (bus.b == DIV0_QUOT);

`ifdef MULDIV_FAST_MUL_EN
    // Operands sign-extended from their 33-bit signed form; the low 2*XLEN
    // bits of the product are exact for every signedness combination.
    logic [2*XLEN-1:0] fast_a, fast_b, fast_prod;
    assign fast_a    = {{XLEN{sa_in}}, bus.a};
    assign fast_b    = {{XLEN{sb_in}}, bus.b};
    assign fast_prod = fast_a * fast_b;
`endif

    // Operations whose result is known at accept time skip the datapath.
    always_comb begin
        direct_done = 1'b0;
        direct_res  = '0;
        case (bus.op)
            OP_DIV, OP_DIVU: begin
                if (b_zero) begin
                    direct_done = 1'b1;
                    direct_res  = DIV0_QUOT;
                end else if (bus.op == OP_DIV && div_ovf) begin
                    direct_done = 1'b1;
                    direct_res  = INT_MIN;
                end
            end
            OP_REM, OP_REMU: begin
                if (b_zero) begin
                    direct_done = 1'b1;
                    direct_res  = bus.a;
                end else if (bus.op == OP_REM && div_ovf) begin
                    direct_done = 1'b1;
                    direct_res  = '0;
                end
            end
            default: begin
`ifdef MULDIV_FAST_MUL_EN
                direct_done = 1'b1;
                direct_res  = (bus.op == OP_MUL) ? fast_prod[XLEN-1:0]
                                                 : fast_prod[2*XLEN-1:XLEN];
`endif
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Iterative datapath
    // ------------------------------------------------------------------
    assign core_load = accept && !direct_done;
    assign core_step = (state_q == CALC);

    muldiv_iter_core u_core (
        .clk    (clk),
        .rst    (rst),
        .load   (core_load),
        .step   (core_step),
`ifndef MULDIV_FAST_MUL_EN
        .is_mul (~op_q[2]),
`endif
        .a_mag  (a_mag),
        .b_mag  (b_mag),
        .hi     (core_hi),
        .lo     (core_lo)
    );

    // ------------------------------------------------------------------
    // Sign fix-up and result selection
    // ------------------------------------------------------------------
`ifndef MULDIV_FAST_MUL_EN
    // High word of the negated 64-bit product: ~hi plus the carry that the
    // +1 of the negation produces only when the low word is zero.
    logic [XLEN-1:0] mul_hi_fix;
    assign mul_hi_fix = (sa_q ^ sb_q) ? (~core_hi + XLEN'(core_lo == '0)) : core_hi;
`endif

    always_comb begin
        fix_res = '0;
        case (op_q)
            OP_DIV, OP_DIVU: fix_res = neg_if(sa_q ^ sb_q, core_lo);
            OP_REM, OP_REMU: fix_res = neg_if(sa_q, core_hi);
`ifndef MULDIV_FAST_MUL_EN
            OP_MUL:          fix_res = core_lo;
            default:         fix_res = mul_hi_fix;
`else
            default:         fix_res = '0;
`endif
        endcase
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = direct_done ? DONE : CALC;
            CALC: begin
                if (bus.flush)                          state_d = IDLE;
                else if (cnt_q == CNT_W'(ITER - 1))     state_d = FIX;
            end
            FIX:     state_d = bus.flush ? IDLE : DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            op_q     <= '0;
            wa_q     <= '0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
            wa_out_q <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        op_q  <= bus.op;
                        wa_q  <= bus.wa_in;
                        sa_q  <= sa_in;
                        sb_q  <= sb_in;
                        cnt_q <= '0;
                        if (direct_done) begin
                            result_q <= direct_res;
                            wa_out_q <= bus.wa_in;
                        end
                    end
                end
                CALC: cnt_q <= cnt_q + CNT_W'(1);
                FIX: begin
                    // A flushed op must not disturb the last delivered result.
                    if (!bus.flush) begin
                        result_q <= fix_res;
                        wa_out_q <= wa_q;
                    end
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // stall drops in DONE so the pipeline advances on the edge that consumes
    // the result.
    assign bus.stall        = accept || (state_q == CALC) || (state_q == FIX);
    assign bus.busy         = (state_q != IDLE);
    assign bus.result_valid = (state_q == DONE);
    assign bus.result       = result_q;
    assign bus.wa_out       = wa_out_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb_ex_muldiv_unit -- scoreboard bench for ex_muldiv_unit. Directed vectors
// push expected {result, wa_out, cycle} entries; a negedge monitor pops and
// compares each result_valid strobe. Honours MULDIV_FAST_MUL_EN for multiply
// latency.
module tb_ex_muldiv_unit;
    import muldiv_pkg::*;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = ITER + 2;
`endif
    localparam int DIV_LAT = ITER + 2;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  wa;
        int          cyc;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   total;
    int   bad;
    exp_t exp_q[$];

    ex_muldiv_unit_if bus ();

    ex_muldiv_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Monitor: compares every result strobe against the scoreboard head.
    always @(negedge clk) begin
        exp_t e;
        if (rst !== 1'b1 && bus.result_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_result_valid: result=0x%0h wa_out=%0d at cycle %0d",
                         bus.result, bus.wa_out, cyc);
            end else begin
                e = exp_q.pop_front();
                check("result", bus.result, e.res);
                check("wa_out", bus.wa_out, e.wa);
                check("result_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Present one request for a single cycle; lat==0 means no result expected.
    task automatic issue(input logic [2:0] op_i, input logic [31:0] a_i, input logic [31:0] b_i,
                         input logic [4:0] wa_i, input logic [31:0] exp_res, input int lat);
        exp_t e;
        bus.req_valid = 1'b1;
        bus.op        = op_i;
        bus.a         = a_i;
        bus.b         = b_i;
        bus.wa_in     = wa_i;
        if (lat > 0) begin
            e.res = exp_res;
            e.wa  = wa_i;
            e.cyc = cyc + lat;
            exp_q.push_back(e);
        end
        next_cycle();
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.busy === 1'b1 && n < 100) begin
            next_cycle();
            n++;
        end
        check("idle_timeout", {63'd0, bus.busy}, 64'd0);
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) next_cycle();
    endtask

    initial begin
        int c0;
        int stall_err;

        total         = 0;
        bad           = 0;
        rst           = 1'b1;
        bus.flush     = 1'b0;
        bus.req_valid = 1'b0;
        bus.op        = OP_MUL;
        bus.a         = '0;
        bus.b         = '0;
        bus.wa_in     = '0;

        // Reset state
        repeat (3) next_cycle();
        check("rst_result", bus.result, 32'h0);
        check("rst_wa_out", bus.wa_out, 5'd0);
        check("rst_result_valid", bus.result_valid, 1'b0);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_stall", bus.stall, 1'b0);
        rst = 1'b0;
        next_cycle();

        // DIV -7/2 with req_valid held as a stalled pipeline would hold it
        c0 = cyc;
        bus.req_valid = 1'b1;
        bus.op        = OP_DIV;
        bus.a         = 32'hFFFF_FFF9;
        bus.b         = 32'd2;
        bus.wa_in     = 5'd5;
        exp_q.push_back('{res: 32'hFFFF_FFFD, wa: 5'd5, cyc: c0 + DIV_LAT});
        stall_err = 0;
        for (int k = 0; k <= DIV_LAT; k++) begin
            @(negedge clk);
            if (bus.stall !== (k <= DIV_LAT - 1)) stall_err++;
            next_cycle();
        end
        bus.req_valid = 1'b0;
        check("div_stall_window", stall_err, 0);
        check("div_no_reaccept", bus.busy, 1'b0);
        wait_idle();

        // Iterative signed/unsigned divides
        issue(OP_REM,  32'hFFFF_FFF9, 32'd2,         5'd6,  32'hFFFF_FFFF, DIV_LAT); wait_idle();
        issue(OP_DIV,  32'd7,         32'hFFFF_FFFE, 5'd15, 32'hFFFF_FFFD, DIV_LAT); wait_idle();
        issue(OP_REM,  32'd7,         32'hFFFF_FFFE, 5'd16, 32'd1,         DIV_LAT); wait_idle();
        issue(OP_DIVU, 32'd100,       32'd7,         5'd12, 32'd14,        DIV_LAT); wait_idle();
        issue(OP_REMU, 32'd100,       32'd7,         5'd13, 32'd2,         DIV_LAT); wait_idle();

        // Special cases finish the cycle after accept
        issue(OP_REMU, 32'd7, 32'd0, 5'd7, 32'd7, 1);
        wait_idle();
        check("result_hold", bus.result, 32'd7);
        issue(OP_DIVU, 32'd5,         32'd0,         5'd8,  32'hFFFF_FFFF, 1); wait_idle();
        issue(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'h8000_0000, 1); wait_idle();
        issue(OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h0,         1); wait_idle();

        // Multiplies
        issue(OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd14, 32'h0000_0001, MUL_LAT);
        check("mul_stall_after_accept", bus.stall, (MUL_LAT == 1) ? 1'b0 : 1'b1);
        wait_idle();
        issue(OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd17, 32'h0000_0000, MUL_LAT); wait_idle();
        issue(OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd18, 32'hFFFF_FFFE, MUL_LAT); wait_idle();
        issue(OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd19, 32'hFFFF_FFFF, MUL_LAT); wait_idle();
        issue(OP_MULH,   32'hFFFF_FFFD, 32'd5,         5'd20, 32'hFFFF_FFFF, MUL_LAT); wait_idle();
        issue(OP_MUL,    32'hFFFF_FFFD, 32'd5,         5'd21, 32'hFFFF_FFF1, MUL_LAT); wait_idle();

        // flush together with req_valid in IDLE: request ignored
        bus.req_valid = 1'b1;
        bus.flush     = 1'b1;
        bus.op        = OP_DIV;
        bus.a         = 32'd9;
        bus.b         = 32'd3;
        bus.wa_in     = 5'd22;
        #1;
        check("flush_req_stall", bus.stall, 1'b0);
        next_cycle();
        bus.req_valid = 1'b0;
        bus.flush     = 1'b0;
        check("flush_req_busy", bus.busy, 1'b0);

        // flush during CALC, then a new MUL right away
        c0 = cyc;
        issue(OP_DIVU, 32'd100, 32'd7, 5'd23, 32'd0, 0);
        wait_until(c0 + 10);
        bus.flush = 1'b1;
        next_cycle();
        bus.flush = 1'b0;
        check("flush_calc_busy", bus.busy, 1'b0);
        check("flush_calc_stall", bus.stall, 1'b0);
        issue(OP_MUL, 32'd3, 32'd4, 5'd9, 32'd12, MUL_LAT);
        wait_idle();

        // flush during FIX: no result, previous result kept
        c0 = cyc;
        issue(OP_DIV, 32'd20, 32'd3, 5'd24, 32'd0, 0);
        wait_until(c0 + ITER + 1);
        check("fix_stall", bus.stall, 1'b1);
        bus.flush = 1'b1;
        next_cycle();
        bus.flush = 1'b0;
        check("flush_fix_busy", bus.busy, 1'b0);
        check("flush_fix_result_kept", bus.result, 32'd12);

        // flush during DONE: result still delivered
        c0 = cyc;
        issue(OP_DIVU, 32'd100, 32'd7, 5'd3, 32'd14, DIV_LAT);
        wait_until(c0 + DIV_LAT);
        bus.flush = 1'b1;
        next_cycle();
        bus.flush = 1'b0;
        wait_idle();

        // reset in the middle of a DIV
        c0 = cyc;
        issue(OP_DIV, 32'd100, 32'd7, 5'd25, 32'd0, 0);
        wait_until(c0 + 20);
        rst = 1'b1;
        next_cycle();
        check("midrst_result", bus.result, 32'h0);
        check("midrst_wa_out", bus.wa_out, 5'd0);
        check("midrst_busy", bus.busy, 1'b0);
        check("midrst_stall", bus.stall, 1'b0);
        rst = 1'b0;
        repeat (40) next_cycle();

        check("pending_expectations", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit in the execute stage, directly downstream of the ID/EX pipeline register.
- Consumes the operation, the forwarded operands and the destination register of an M-extension instruction.
- Asserts a stall that freezes the front-end pipeline registers while it iterates.
- Returns a 32-bit result plus the destination register to the EX/MEM path.

Parameters:
- XLEN, 32, operand/result width; ITER = XLEN shift/add-subtract steps.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous active-high reset
- flush  in  1  abort in-flight op (same flush that clears ID/EX)
- req_valid  in  1  M-ext instruction present in EX this cycle
- op  in  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- a  in  XLEN  rs1 value (post-forwarding)
- b  in  XLEN  rs2 value (post-forwarding)
- wa_in  in  5  destination register
- stall  out  1  hold upstream pipeline registers
- busy  out  1  FSM not in IDLE
- result_valid  out  1  one-cycle result strobe
- result  out  XLEN  final result
- wa_out  out  5  destination register of the result

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE; result=0; wa_out=0; result_valid=0; busy=0; all internal registers 0.
  - Mid-operation reset abandons the op; no result_valid follows.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - If req_valid and not flush, the op is accepted at edge N: capture op and wa_in.
  - Capture magnitudes of a and b. Signed when op is MULH/DIV/REM, or for a only under MULHSU.
  - Record the sign flags.
  - Special cases go directly to DONE at N+1, so result_valid is high in cycle N+1:
    - b==0 with op DIV/DIVU: result 0xFFFFFFFF.
    - b==0 with op REM/REMU: result a.
    - a==0x80000000 and b==0xFFFFFFFF with op DIV: result 0x80000000.
    - Same operands with op REM: result 0.
  - Otherwise go to CALC with cnt=0.
- CALC:
  - Exactly ITER cycles; cnt increments and leaves at cnt==ITER-1.
  - Multiply: unsigned shift-add into a 2*XLEN product.
  - Divide: restoring; shift the remainder left, subtract the divisor, set the quotient bit if non-negative.
- FIX (1 cycle):
  - Multiply: negate the product when the signs differ (MULH, MULHSU).
  - DIV: negate the quotient when the signs differ.
  - REM: the remainder takes the sign of a.
  - Select the result: low word for MUL, high word for MULH*, quotient or remainder for divides.
- DONE (1 cycle):
  - result_valid=1; result and wa_out are valid; return to IDLE.
  - Normal-path latency: accept at N, result_valid at N+ITER+2 (N+34).
- stall (combinational):
  - 1 when (IDLE and req_valid and not flush), or state is CALC or FIX.
  - 0 in DONE, so the pipeline advances on the same edge the result is consumed.
- busy=1 in CALC, FIX and DONE.
- result and wa_out hold their last value after DONE until the next op completes.
- flush:
  - In CALC or FIX: next state IDLE, no result_valid.
  - In DONE: result_valid still asserts that cycle (the instruction already committed to EX/MEM), then IDLE.
  - flush and req_valid together in IDLE: the request is ignored.
- req_valid while busy: ignored. Upstream is stalled, so this only reflects the same held instruction.

Optional Feature:
- Macro MULDIV_FAST_MUL_EN.
- Defined:
  - Multiply ops use a combinational signed 33x33 product.
  - They go IDLE→DONE, so result_valid is at N+1 and stall is high only in the accept cycle.
  - Divides are unchanged.
- Undefined: all multiplies iterate as above (N+34). The iterative multiply datapath must not be synthesised when the macro is defined.

Decomposition:
- Shared package muldiv_pkg contains:
  - op encodings (localparams OP_MUL..OP_REMU)
  - the state encoding (IDLE, CALC, FIX, DONE)
  - ITER
  - the constants DIV0_QUOT=0xFFFFFFFF and INT_MIN=0x80000000
- One sub-module, muldiv_iter_core, holds the per-cycle shift/add/subtract datapath: remainder/product register, quotient register, step enable.
- The FSM, special-case detection and sign fix-up stay in ex_muldiv_unit.

Test Plan:
- DIV a=-7 (0xFFFFFFF9), b=2, accept at cycle 0 → stall high cycles 0-33; result_valid at cycle 34 with result 0xFFFFFFFD (-3) and wa_out=wa_in.
- REM a=-7, b=2 → 0xFFFFFFFF (-1). REMU a=7, b=0 → result 7 at cycle 1. DIVU a=5, b=0 → 0xFFFFFFFF at cycle 1.
- DIV a=0x80000000, b=0xFFFFFFFF → 0x80000000 at cycle 1. REM with the same operands → 0.
- Multiply a=0xFFFFFFFF, b=0xFFFFFFFF:
  - MUL → 0x00000001; MULH → 0x00000000; MULHU → 0xFFFFFFFE; MULHSU → 0xFFFFFFFF.
  - Latency is 34 without MULDIV_FAST_MUL_EN and 1 with it.
- DIVU 100/7 started, flush asserted at cycle 10 → state IDLE at cycle 11, no result_valid, stall low. A new MUL 3*4 accepted at cycle 11 → 12.
- rst asserted at cycle 20 of a DIV → at the next edge all outputs are 0 and state is IDLE; no result_valid appears afterwards.
